// File: rtl/ifm_feeder_8.sv
// ifm_feeder_8: input-feature feeder for the 8-bit binary-serial systolic array.
// One HEIGHT-wide vector is accepted per handshake. Each operand is held for SDEPTH
// serial cycles. Row h sees the row-0 timing delayed by h cycles, so the operands
// enter the array as a diagonal wavefront.
// rst_n is active-high despite its name: a 1 sampled on a clk edge resets the block.
module ifm_feeder_8 #(
  parameter int HEIGHT = 8,
  parameter int IWIDTH = 8,
  parameter int SDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] in_data [HEIGHT],
  input  logic                     in_first,
  input  logic                     in_last,
  output logic signed [IWIDTH-1:0] ifm [HEIGHT],
  output logic [HEIGHT-1:0]        en_i,
  output logic [HEIGHT-1:0]        clr_i,
  output logic [HEIGHT-1:0]        mac_done,
  output logic                     busy,
  output logic                     tile_done
);

  localparam int CW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SDEPTH - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cntNext;
  logic            r_first;
  logic            r_last;
  logic            w_firstNext;
  logic            w_lastNext;
  logic            w_accept;

  logic signed [IWIDTH-1:0] r_cap [HEIGHT];

  // Bit h of each pipe is the control for row h; bit 0 is the row-0 lane itself.
  logic [HEIGHT-1:0] r_enPipe;
  logic [HEIGHT-1:0] r_clrPipe;
  logic [HEIGHT-1:0] r_mdPipe;
  logic [HEIGHT-1:0] r_lastPipe;
  logic              r_tileDone;

  logic w_en0Next;
  logic w_clr0Next;
  logic w_md0Next;
  logic w_last0Next;

  // Next-state, counter and handshake decode; ready opens only on the final hold cycle.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_firstNext = r_first;
    w_lastNext  = r_last;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_stateNext = HOLD;
          w_cntNext   = '0;
        end
      end
      HOLD: begin
        if (r_cnt == CNT_LAST) begin
          in_ready  = 1'b1;
          w_cntNext = '0;
          if (in_valid) begin
            w_accept = 1'b1;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
    if (w_accept) begin
      w_firstNext = in_first;
      w_lastNext  = in_last;
    end
  end

  // Row-0 controls are decoded from the next state so the lane registers line up with HOLD.
  assign w_en0Next   = (w_stateNext == HOLD);
  assign w_clr0Next  = w_en0Next && (w_cntNext == '0) && w_firstNext;
  assign w_md0Next   = w_en0Next && (w_cntNext == CNT_LAST);
  assign w_last0Next = w_md0Next && w_lastNext;

  // FSM state, serial counter, control skew pipes and the tile-done pulse.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_enPipe   <= '0;
      r_clrPipe  <= '0;
      r_mdPipe   <= '0;
      r_lastPipe <= '0;
      r_tileDone <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_first    <= w_firstNext;
      r_last     <= w_lastNext;
      r_enPipe   <= {r_enPipe[HEIGHT-2:0], w_en0Next};
      r_clrPipe  <= {r_clrPipe[HEIGHT-2:0], w_clr0Next};
      r_mdPipe   <= {r_mdPipe[HEIGHT-2:0], w_md0Next};
      r_lastPipe <= {r_lastPipe[HEIGHT-2:0], w_last0Next};
      r_tileDone <= r_lastPipe[HEIGHT-1];
    end
  end

  // Capture every row's operand at acceptance; it stays put for the whole hold window.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int h = 0; h < HEIGHT; h++) begin
        r_cap[h] <= '0;
      end
    end else if (w_accept) begin
      for (int h = 0; h < HEIGHT; h++) begin
        r_cap[h] <= in_data[h];
      end
    end
  end

  // Each row h>0 gets its own h-deep data delay line fed from its captured operand.
  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    if (h == 0) begin : g_direct
      assign ifm[0] = r_cap[0];
    end else begin : g_dly
      logic signed [IWIDTH-1:0] r_line [0:h-1];

      // Shift row h's operand one stage per cycle toward the array edge.
      always_ff @(posedge clk) begin
        if (rst_n) begin
          for (int k = 0; k < h; k++) begin
            r_line[k] <= '0;
          end
        end else begin
          r_line[0] <= r_cap[h];
          for (int k = 1; k < h; k++) begin
            r_line[k] <= r_line[k-1];
          end
        end
      end

      assign ifm[h] = r_line[h-1];
    end
  end

  assign en_i      = r_enPipe;
  assign clr_i     = r_clrPipe;
  assign mac_done  = r_mdPipe;
  assign tile_done = r_tileDone;
  assign busy      = (r_state == HOLD) || (|r_enPipe);

endmodule

// File: tb/tb_ifm_feeder_8.sv
// Testbench for ifm_feeder_8: a directed table for the single-vector case, a
// timestamp-based expectation for multi-vector sequences, plus reset and small-parameter cases.
module tb_ifm_feeder_8;

  localparam int H  = 8;
  localparam int SD = 8;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_n;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_data [H];
  logic                 in_first;
  logic                 in_last;
  logic signed [W-1:0]  ifm [H];
  logic [H-1:0]         en_i;
  logic [H-1:0]         clr_i;
  logic [H-1:0]         mac_done;
  logic                 busy;
  logic                 tile_done;

  logic                 in_valid4;
  logic                 in_ready4;
  logic signed [W-1:0]  in_data4 [4];
  logic                 in_first4;
  logic                 in_last4;
  logic signed [W-1:0]  ifm4 [4];
  logic [3:0]           en_i4;
  logic [3:0]           clr_i4;
  logic [3:0]           mac_done4;
  logic                 busy4;
  logic                 tile_done4;

  ifm_feeder_8 #(.HEIGHT(H), .IWIDTH(W), .SDEPTH(SD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .in_last(in_last), .ifm(ifm),
    .en_i(en_i), .clr_i(clr_i), .mac_done(mac_done), .busy(busy), .tile_done(tile_done)
  );

  ifm_feeder_8 #(.HEIGHT(4), .IWIDTH(W), .SDEPTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_first(in_first4), .in_last(in_last4), .ifm(ifm4),
    .en_i(en_i4), .clr_i(clr_i4), .mac_done(mac_done4), .busy(busy4), .tile_done(tile_done4)
  );

  always #5 clk = ~clk;

  // Cycle number as seen #1 after each rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic           valid;
    logic           first;
    logic           last;
    logic [H*W-1:0] data;
    logic [H-1:0]   en;
    logic [H-1:0]   clr;
    logic [H-1:0]   md;
    logic           busyExp;
    logic           tile;
    logic           ready;
  } vec_t;

  vec_t tbl [19];

  // Accepted vectors: cycle value just before the accepting edge, flags and data.
  int             accCyc   [8];
  logic           accFirst [8];
  logic           accLast  [8];
  logic [H*W-1:0] accData  [8];
  int             nAcc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic driveRows(input logic v, input logic f, input logic l, input logic [H*W-1:0] p);
    in_valid = v;
    in_first = f;
    in_last  = l;
    for (int h = 0; h < H; h++) in_data[h] = p[h*W +: W];
  endtask

  function automatic logic [H*W-1:0] splat(input logic [W-1:0] v);
    logic [H*W-1:0] p;
    for (int h = 0; h < H; h++) p[h*W +: W] = v;
    return p;
  endfunction

  task automatic addAcc(input logic f, input logic l, input logic [H*W-1:0] p);
    accCyc[nAcc]   = cyc;
    accFirst[nAcc] = f;
    accLast[nAcc]  = l;
    accData[nAcc]  = p;
    nAcc++;
  endtask

  // Expected outputs derived from the handshake timestamps and the row-h skew rule.
  task automatic checkAll();
    logic [H-1:0]   eEn, eClr, eMd;
    logic [H*W-1:0] eIfm;
    logic           eBusy, eTile, inWin0, atEnd0;
    logic [W-1:0]   a8;
    int             d, a;
    eEn = '0; eClr = '0; eMd = '0; eIfm = '0;
    eBusy = 1'b0; eTile = 1'b0; inWin0 = 1'b0; atEnd0 = 1'b0;
    for (int i = 0; i < nAcc; i++) begin
      a = accCyc[i];
      for (int h = 0; h < H; h++) begin
        d = cyc - a - h;
        if (d >= 1 && d <= SD) begin
          eEn[h] = 1'b1;
          eIfm[h*W +: W] = accData[i][h*W +: W];
          if (d == 1 && accFirst[i]) eClr[h] = 1'b1;
          if (d == SD) eMd[h] = 1'b1;
        end
      end
      if (cyc - a >= 1 && cyc - a <= SD) inWin0 = 1'b1;
      if (cyc - a == SD) atEnd0 = 1'b1;
      if (cyc - a >= 1 && cyc - a <= SD + H - 1) eBusy = 1'b1;
      if (cyc - a == SD + H && accLast[i]) eTile = 1'b1;
    end
    checkOutput("en_i", en_i, eEn);
    checkOutput("clr_i", clr_i, eClr);
    checkOutput("mac_done", mac_done, eMd);
    checkOutput("busy", busy, eBusy);
    checkOutput("tile_done", tile_done, eTile);
    checkOutput("in_ready", in_ready, (!inWin0) || atEnd0);
    for (int h = 0; h < H; h++) begin
      if (eEn[h]) begin
        a8 = ifm[h];
        checkOutput($sformatf("ifm[%0d]", h), a8, eIfm[h*W +: W]);
      end
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      checkAll();
    end
  endtask

  // Plays the single-vector table: inputs applied, outputs compared, then one clock.
  task automatic applyStimulus();
    logic [W-1:0] a8;
    for (int k = 0; k < 19; k++) begin
      driveRows(tbl[k].valid, tbl[k].first, tbl[k].last, tbl[k].data);
      checkOutput($sformatf("s2_en k=%0d", k), en_i, tbl[k].en);
      checkOutput($sformatf("s2_clr k=%0d", k), clr_i, tbl[k].clr);
      checkOutput($sformatf("s2_md k=%0d", k), mac_done, tbl[k].md);
      checkOutput($sformatf("s2_busy k=%0d", k), busy, tbl[k].busyExp);
      checkOutput($sformatf("s2_tile k=%0d", k), tile_done, tbl[k].tile);
      checkOutput($sformatf("s2_ready k=%0d", k), in_ready, tbl[k].ready);
      for (int h = 0; h < H; h++) begin
        if (tbl[k].en[h]) begin
          a8 = ifm[h];
          checkOutput($sformatf("s2_ifm[%0d] k=%0d", h, k), a8, W'(h + 1));
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [H*W-1:0] p;
    logic [W-1:0]   a8;
    int             gap;

    // Single vector, data h+1, first=last=1, handshake at entry 0.
    for (int h = 0; h < H; h++) p[h*W +: W] = W'(h + 1);
    for (int k = 0; k < 19; k++) begin
      tbl[k].valid   = (k == 0);
      tbl[k].first   = 1'b1;
      tbl[k].last    = 1'b1;
      tbl[k].data    = p;
      tbl[k].busyExp = (k >= 1) && (k <= 15);
      tbl[k].tile    = (k == 16);
      tbl[k].ready   = (k == 0) || (k >= 8);
      for (int h = 0; h < H; h++) begin
        tbl[k].en[h]  = (k - h >= 1) && (k - h <= 8);
        tbl[k].clr[h] = (k - h == 1);
        tbl[k].md[h]  = (k - h == 8);
      end
    end

    driveRows(1'b0, 1'b0, 1'b0, '0);
    in_valid4 = 1'b0; in_first4 = 1'b0; in_last4 = 1'b0;
    for (int h = 0; h < 4; h++) in_data4[h] = '0;

    // Reset held for two cycles, then idle.
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    checkAll();
    for (int h = 0; h < H; h++) begin
      a8 = ifm[h];
      checkOutput($sformatf("reset_ifm[%0d]", h), a8, '0);
    end
    checkOutput("reset_en4", en_i4, 4'h0);
    checkOutput("reset_ready4", in_ready4, 1'b1);
    checkOutput("reset_busy4", busy4, 1'b0);
    runCycles(2);

    // Single-vector tile.
    applyStimulus();

    // Back-to-back: -128, 127, -1 with valid held high.
    nAcc = 0;
    driveRows(1'b1, 1'b1, 1'b0, splat(8'h80));
    addAcc(1'b1, 1'b0, splat(8'h80));
    runCycles(8);
    driveRows(1'b1, 1'b0, 1'b0, splat(8'h7F));
    addAcc(1'b0, 1'b0, splat(8'h7F));
    runCycles(8);
    driveRows(1'b1, 1'b0, 1'b1, splat(8'hFF));
    addAcc(1'b0, 1'b1, splat(8'hFF));
    runCycles(1);
    in_valid = 1'b0;
    runCycles(19);

    // Stall of five cycles between two vectors.
    nAcc = 0;
    driveRows(1'b1, 1'b1, 1'b0, splat(8'd33));
    addAcc(1'b1, 1'b0, splat(8'd33));
    runCycles(1);
    in_valid = 1'b0;
    runCycles(7);
    gap = 0;
    repeat (5) begin
      runCycles(1);
      if (!en_i[0]) gap++;
    end
    checkOutput("s4_gap", gap, 5);
    driveRows(1'b1, 1'b0, 1'b1, splat(8'hF9));
    addAcc(1'b0, 1'b1, splat(8'hF9));
    runCycles(1);
    in_valid = 1'b0;
    runCycles(18);

    // Reset in HOLD at counter 3, then a fresh single vector.
    nAcc = 0;
    driveRows(1'b1, 1'b0, 1'b1, splat(8'd5));
    addAcc(1'b0, 1'b1, splat(8'd5));
    runCycles(1);
    in_valid = 1'b0;
    runCycles(3);
    rst_n = 1'b1;
    nAcc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    checkAll();
    for (int h = 0; h < H; h++) begin
      a8 = ifm[h];
      checkOutput($sformatf("s5_ifm[%0d]", h), a8, '0);
    end
    runCycles(17);
    applyStimulus();

    // Small instance: HEIGHT=4, SDEPTH=2.
    in_valid4 = 1'b1; in_first4 = 1'b1; in_last4 = 1'b1;
    for (int h = 0; h < 4; h++) in_data4[h] = W'(10 * (h + 1));
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("s6_en0 k=%0d", k), en_i4[0], (k >= 1) && (k <= 2));
      checkOutput($sformatf("s6_en3 k=%0d", k), en_i4[3], (k >= 4) && (k <= 5));
      checkOutput($sformatf("s6_md3 k=%0d", k), mac_done4[3], (k == 5));
      checkOutput($sformatf("s6_tile k=%0d", k), tile_done4, (k == 6));
      if (k == 4) begin
        a8 = ifm4[3];
        checkOutput("s6_ifm3", a8, 8'd40);
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifm_feeder_8.md
Name: ifm_feeder_8

Overview:
Upstream input-feeder stage for the 8-bit binary-serial systolic array. It accepts one HEIGHT-wide input-feature vector per handshake and holds each operand for SDEPTH serial cycles. It generates the per-row en_i, clr_i and mac_done controls, and skews row h by h cycles so that the wavefront matches the array's west-edge timing. It also reports when the last vector of a tile has fully left the last row.

Parameters:
HEIGHT, 8, number of array rows (output lanes).
IWIDTH, 8, signed operand width.
SDEPTH, 8, serial cycles each operand is held (the MAC length per operand); must be >= 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-high (asserted = 1 resets on the next clk edge).
in_valid  input  1  upstream vector valid.
in_ready  output  1  feeder can accept a vector this cycle.
in_data  input  IWIDTH x HEIGHT (unpacked, signed)  element h goes to row h.
in_first  input  1  qualifies in_data; the vector starts a new accumulation (drives clr_i).
in_last  input  1  qualifies in_data; the vector ends the tile.
ifm  output  IWIDTH x HEIGHT (unpacked, signed)  per-row operand to the array.
en_i  output  HEIGHT  per-row operand enable.
clr_i  output  HEIGHT  per-row accumulator clear.
mac_done  output  HEIGHT  per-row end-of-operand strobe.
busy  output  1  any vector is held or any skew stage is occupied.
tile_done  output  1  one-cycle pulse when the in_last vector's mac_done leaves row HEIGHT-1.

Behaviour:
- Reset:
  - All outputs are 0, except in_ready, which is 1.
  - FSM goes to IDLE, the serial counter to 0, and all skew registers to 0.
  - Reset mid-operation discards the held vector and everything in flight; no tile_done pulse.
- FSM states: IDLE, HOLD.
  - IDLE: in_ready = 1. On in_valid, capture in_data, in_first and in_last; counter = 0; go to HOLD.
  - HOLD: the counter increments each cycle from 0 to SDEPTH-1.
  - HOLD, in_ready: 1 only when counter == SDEPTH-1, so back-to-back vectors are accepted with no bubble.
  - HOLD exit at counter == SDEPTH-1: with in_valid, capture the new vector, reset the counter and stay in HOLD. Without in_valid, go to IDLE.
- Row-0 lane (registered): a handshake at edge t gives a row-0 hold window on cycles t+1 .. t+SDEPTH.
  - en_i[0] = 1 for the whole window.
  - ifm[0] = captured in_data[0] for the whole window.
  - clr_i[0] = 1 on the first window cycle only, and only if the captured in_first = 1.
  - mac_done[0] = 1 on the last window cycle only.
- Outside hold windows:
  - en_i, clr_i and mac_done are 0.
  - ifm retains its last value (no requirement on the value when en_i = 0).
- Skew:
  - Row h outputs (en_i, clr_i, mac_done, and a per-row data register carrying in_data[h]) equal the row-0 lane timing delayed by exactly h cycles.
  - Implemented as h-deep shift registers per row. Row h data is captured at acceptance and released into its delay line; rows do not share data.
- Latency: handshake at edge t gives en_i[h] first high at cycle t+1+h; mac_done[HEIGHT-1] is high at cycle t+SDEPTH+HEIGHT-1.
- tile_done:
  - A last-flag travels with mac_done through the row HEIGHT-1 delay line.
  - tile_done = 1 in the cycle after mac_done[HEIGHT-1] = 1 with the last-flag set.
  - Exactly one pulse per in_last vector.
- busy: 1 while the FSM is in HOLD or any skew register holds en = 1; it is 0 again the cycle after the final row's window ends.
- in_first and in_last may both be 1 on the same vector (a single-vector tile): clr on the first cycle, tile_done after drain.
- in_valid while in_ready = 0 is ignored; upstream must hold the vector (valid/ready rule: transfer occurs only on valid & ready).
- No overflow or arithmetic: data pass through unmodified and sign is preserved.

Test Plan:
1. Reset, then idle: rst_n = 1 for 2 cycles -> all en_i, clr_i and mac_done = 0; in_ready = 1; busy = 0; tile_done = 0.
2. Single vector: in_data[h] = h+1, in_first = in_last = 1, accepted at t0.
   - en_i[h] is high for cycles t0+1+h .. t0+8+h, with ifm[h] = h+1.
   - clr_i[h] is high at t0+1+h only; mac_done[h] is high at t0+8+h only.
   - tile_done pulses at t0+16; busy falls at t0+16.
3. Back-to-back: 3 vectors with in_valid held high, values -128, 127, -1 on all rows, in_first on the 1st and in_last on the 3rd.
   - in_ready is high at counter 7 only, so there are no gaps in en_i[0] for 24 cycles.
   - clr_i pulses once per row; mac_done pulses 3 times per row.
   - ifm keeps exact signed values; tile_done pulses once.
4. Stall: in_valid drops for 5 cycles between vectors -> en_i[0] is low for exactly 5 cycles; row skew is preserved; no spurious mac_done.
5. Reset mid-HOLD at counter 3 -> the next cycle shows all outputs 0 and busy = 0; no tile_done; a fresh vector afterwards behaves exactly as in scenario 2.
6. Parameter check with HEIGHT = 4, SDEPTH = 2 -> row 3 en_i is high at t0+4 .. t0+5; tile_done pulses at t0+6.
